// File: rtl/tge_tx_playback.sv
`default_nettype none
// ============================================================================
//  Module   : tge_tx_playback
//  Purpose  : Streams one frame from a 128-bit BRAM (port A) into the TGE TX
//             interface as 64-bit beats, low half first, with tx_afull
//             back-pressure, completion pulse, frame counter and sticky
//             overflow status.
//  Revision : 1.0  initial release
// ============================================================================
module tge_tx_playback #(
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic [31:0]           dest_ip,
  input  logic [15:0]           dest_port,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
  output logic [31:0]           frame_count,
  output logic                  bram_en_a,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [127:0]          bram_rd_data,
  output logic [63:0]           tx_data,
  output logic                  tx_valid,
  output logic                  tx_end_of_frame,
  output logic [31:0]           tx_dest_ip,
  output logic [15:0]           tx_dest_port,
  input  logic                  tx_afull,
  input  logic                  tx_overflow
);

  // State name tells which half of the current word was committed last.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [63:0]           hold_hi_q, hold_hi_d;
  logic [63:0]           tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_eof_q, tx_eof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           frame_count_q, frame_count_d;
  logic [31:0]           dest_ip_q, dest_ip_d;
  logic [15:0]           dest_port_q, dest_port_d;

  logic                  start_ok;
  logic                  last_beat;
  logic [LEN_WIDTH-1:0]  last_idx;
  logic [LEN_WIDTH-1:0]  lo_idx;
  logic                  commit_lo;

  assign start_ok  = start & ~busy_q & (num_words != '0);
  assign last_idx  = len_q - LEN_WIDTH'(1);
  assign last_beat = (beat_q == last_idx);
  // Index of the next beat to commit: 0 straight out of LOAD, else one past
  // the beat already on the outputs.
  assign lo_idx    = (state_q == ST_LOAD) ? '0 : beat_q + LEN_WIDTH'(1);

  // Next-state and next-output computation for the playback sequencer.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    hold_hi_d     = hold_hi_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    tx_eof_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ovf_d         = ovf_q;
    en_d          = 1'b0;
    addr_d        = addr_q;
    frame_count_d = frame_count_q;
    dest_ip_d     = dest_ip_q;
    dest_port_d   = dest_port_q;
    commit_lo     = 1'b0;

    if (busy_q && tx_overflow) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (start_ok) begin
          state_d     = ST_FETCH;
          len_d       = num_words;
          dest_ip_d   = dest_ip;
          dest_port_d = dest_port;
          busy_d      = 1'b1;
          ovf_d       = 1'b0;
          en_d        = 1'b1;
          addr_d      = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!tx_afull) begin
          commit_lo = 1'b1;
          state_d   = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (last_beat) begin
          state_d       = ST_FIN;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 32'd1;
        end else if (!tx_afull) begin
          // High half comes from the hold register; BRAM output may already
          // be showing the prefetched next word.
          tx_data_d  = hold_hi_q;
          tx_valid_d = 1'b1;
          beat_d     = lo_idx;
          tx_eof_d   = (lo_idx == last_idx);
          state_d    = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (last_beat) begin
          state_d       = ST_FIN;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 32'd1;
        end else if (!tx_afull) begin
          commit_lo = 1'b1;
          state_d   = ST_SEND_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Low-half commit: send bram_rd_data[63:0], keep the high half for the
    // next beat, and prefetch the following word if it carries any beat.
    if (commit_lo) begin
      tx_data_d  = bram_rd_data[63:0];
      hold_hi_d  = bram_rd_data[127:64];
      tx_valid_d = 1'b1;
      beat_d     = lo_idx;
      tx_eof_d   = (lo_idx == last_idx);
      if (({1'b0, lo_idx} + (LEN_WIDTH+1)'(2)) < {1'b0, len_q}) begin
        en_d   = 1'b1;
        addr_d = ADDR_WIDTH'(lo_idx >> 1) + ADDR_WIDTH'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      beat_q        <= '0;
      hold_hi_q     <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_eof_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      en_q          <= 1'b0;
      addr_q        <= '0;
      frame_count_q <= '0;
      dest_ip_q     <= '0;
      dest_port_q   <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      hold_hi_q     <= hold_hi_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      tx_eof_q      <= tx_eof_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
      en_q          <= en_d;
      addr_q        <= addr_d;
      frame_count_q <= frame_count_d;
      dest_ip_q     <= dest_ip_d;
      dest_port_q   <= dest_port_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign overflow_err    = ovf_q;
  assign frame_count     = frame_count_q;
  assign bram_en_a       = en_q;
  assign bram_addr       = addr_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign tx_end_of_frame = tx_eof_q;
  assign tx_dest_ip      = dest_ip_q;
  assign tx_dest_port    = dest_port_q;

endmodule
`default_nettype wire

// File: tb/tb_tge_tx_playback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tge_tx_playback
//  Purpose  : Directed self-checking bench for tge_tx_playback with a
//             1-cycle-latency BRAM model on port A.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tge_tx_playback;

  localparam int ADDR_WIDTH = 13;
  localparam int LEN_WIDTH  = 14;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [LEN_WIDTH-1:0]  num_words;
  logic [31:0]           dest_ip;
  logic [15:0]           dest_port;
  logic                  busy;
  logic                  done;
  logic                  overflow_err;
  logic [31:0]           frame_count;
  logic                  bram_en_a;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [127:0]          bram_rd_data;
  logic [63:0]           tx_data;
  logic                  tx_valid;
  logic                  tx_end_of_frame;
  logic [31:0]           tx_dest_ip;
  logic [15:0]           tx_dest_port;
  logic                  tx_afull;
  logic                  tx_overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_fc = 32'd0;

  logic [127:0] mem [0:8191];

  // Four-beat frame expectations for cycles 1..7
  localparam logic [63:0] A0 = 64'h1111_1111_AAAA_0000;
  localparam logic [63:0] A1 = 64'h2222_2222_AAAA_0001;
  localparam logic [63:0] B0 = 64'h3333_3333_BBBB_0000;
  localparam logic [63:0] B1 = 64'h4444_4444_BBBB_0001;
  int          e_valid [7] = '{0, 0, 1, 1, 1, 1, 0};
  int          e_eof   [7] = '{0, 0, 0, 0, 0, 1, 0};
  int          e_en    [7] = '{1, 0, 1, 0, 0, 0, 0};
  int          e_addr  [7] = '{0, 0, 1, 1, 1, 1, 1};
  int          e_done  [7] = '{0, 0, 0, 0, 0, 0, 1};
  int          e_busy  [7] = '{1, 1, 1, 1, 1, 1, 0};
  logic [63:0] e_data  [7];

  tge_tx_playback #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_words       (num_words),
    .dest_ip         (dest_ip),
    .dest_port       (dest_port),
    .busy            (busy),
    .done            (done),
    .overflow_err    (overflow_err),
    .frame_count     (frame_count),
    .bram_en_a       (bram_en_a),
    .bram_addr       (bram_addr),
    .bram_rd_data    (bram_rd_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_dest_ip      (tx_dest_ip),
    .tx_dest_port    (tx_dest_port),
    .tx_afull        (tx_afull),
    .tx_overflow     (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM port A: one-cycle read latency, output holds while disabled
  initial bram_rd_data = '0;
  always @(posedge clk) begin
    if (bram_en_a) bram_rd_data <= mem[bram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beatval(input int b, input logic [31:0] seed);
    return {seed, 32'(b)};
  endfunction

  task automatic fill_mem(input logic [31:0] seed);
    for (int w = 0; w < 8192; w++) mem[w] = {beatval(2*w+1, seed), beatval(2*w, seed)};
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: no back-pressure, 1: 5-cycle afull burst at beat 1 then random,
  // 2: ignored mid-frame start. ovf_cyc>0 pulses tx_overflow in that cycle.
  // rst_beat>0 resets after that many beats have been seen.
  task automatic run_frame(input int n, input logic [31:0] seed, input int mode,
                           input int ovf_cyc, input int rst_beat);
    int   beats, bad, eofs, stall_v, en_v, dst_v, maxaddr, done_cyc, burst, seen_done;
    logic prev_af, af, burst_used, done_busy;
    logic [31:0] ip;
    logic [15:0] port;
    string t;
    beats = 0; bad = 0; eofs = 0; stall_v = 0; en_v = 0; dst_v = 0; maxaddr = 0;
    done_cyc = 0; burst = 0; prev_af = 1'b0; burst_used = 1'b0; done_busy = 1'b1;
    ip = seed ^ 32'h0A00_0001;
    port = seed[15:0];
    t = $sformatf("len%0d", n);
    fill_mem(seed);
    start = 1'b1; num_words = LEN_WIDTH'(n); dest_ip = ip; dest_port = port;
    step();
    start = 1'b0;
    chk({t, " busy@1"}, busy, 1);
    chk({t, " ovf clear@1"}, overflow_err, 0);
    chk({t, " en@1"}, bram_en_a, 1);
    for (int cyc = 1; cyc <= 4*n + 40 && done_cyc == 0; cyc++) begin
      if (tx_valid) begin
        if (prev_af) stall_v++;
        if (tx_data !== beatval(beats, seed)) bad++;
        if (tx_end_of_frame) begin
          eofs++;
          if (beats != n-1) bad++;
        end
        beats++;
      end
      if (bram_en_a && cyc > 1 && !tx_valid) en_v++;
      if (int'(bram_addr) > maxaddr) maxaddr = int'(bram_addr);
      if (busy && (tx_dest_ip !== ip || tx_dest_port !== port)) dst_v++;
      if (done) begin
        done_cyc  = cyc;
        done_busy = busy;
      end
      if (rst_beat > 0 && beats == rst_beat) begin
        rst = 1'b1; tx_afull = 1'b0;
        step();
        rst = 1'b0;
        chk({t, " rst ctrl"}, {tx_valid, tx_end_of_frame, busy, done, bram_en_a, overflow_err}, 0);
        chk({t, " rst data"}, tx_data, 0);
        chk({t, " rst addr/fc"}, {bram_addr, frame_count}, 0);
        chk({t, " rst dest"}, {tx_dest_ip, tx_dest_port}, 0);
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
          step();
          if (done || tx_valid) seen_done++;
        end
        chk({t, " quiet after rst"}, seen_done, 0);
        exp_fc = 32'd0;
        return;
      end
      if (mode == 2 && cyc == 4) begin
        start = 1'b1; num_words = LEN_WIDTH'(7); dest_ip = 32'hDEAD_BEEF; dest_port = 16'h1234;
      end else begin
        start = 1'b0;
      end
      tx_overflow = (cyc == ovf_cyc);
      af = 1'b0;
      if (mode == 1) begin
        if (!burst_used && tx_valid && beats == 2) begin
          burst = 5;
          burst_used = 1'b1;
        end
        if (burst > 0) begin
          af = 1'b1;
          burst--;
        end else begin
          af = ($urandom_range(0, 2) == 0);
        end
      end
      tx_afull = af;
      prev_af = af;
      step();
    end
    start = 1'b0; tx_afull = 1'b0; tx_overflow = 1'b0;
    exp_fc = exp_fc + 32'd1;
    chk({t, " beats"}, beats, n);
    chk({t, " data/eof order"}, bad, 0);
    chk({t, " eof count"}, eofs, 1);
    chk({t, " valid after afull"}, stall_v, 0);
    chk({t, " en while idle"}, en_v, 0);
    chk({t, " dest stable"}, dst_v, 0);
    chk({t, " max addr"}, maxaddr, (n+1)/2 - 1);
    chk({t, " done seen"}, (done_cyc != 0), 1);
    chk({t, " busy at done"}, done_busy, 0);
    if (mode != 1) chk({t, " done cycle"}, done_cyc, n + 3);
    chk({t, " done width"}, done, 0);
    chk({t, " frame_count"}, frame_count, exp_fc);
    chk({t, " ovf sticky"}, overflow_err, (ovf_cyc > 0) ? 1 : 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; dest_ip = '0; dest_port = '0;
    tx_afull = 1'b0; tx_overflow = 1'b0;
    e_data = '{64'h0, 64'h0, A0, A1, B0, B1, 64'h0};
    for (int w = 0; w < 8192; w++) mem[w] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    // Reset state
    chk("reset ctrl", {busy, done, overflow_err, bram_en_a, tx_valid, tx_end_of_frame}, 0);
    chk("reset counters", {frame_count, bram_addr}, 0);
    chk("reset dest", {tx_dest_ip, tx_dest_port}, 0);
    chk("reset data", tx_data, 0);

    // Four-beat frame, cycle-exact
    mem[0] = {A1, A0};
    mem[1] = {B1, B0};
    start = 1'b1; num_words = LEN_WIDTH'(4); dest_ip = 32'hC0A8_0001; dest_port = 16'd5000;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("4beat c%0d valid", c), tx_valid, e_valid[c-1]);
      chk($sformatf("4beat c%0d eof", c), tx_end_of_frame, e_eof[c-1]);
      chk($sformatf("4beat c%0d en", c), bram_en_a, e_en[c-1]);
      chk($sformatf("4beat c%0d addr", c), bram_addr, e_addr[c-1]);
      chk($sformatf("4beat c%0d done", c), done, e_done[c-1]);
      chk($sformatf("4beat c%0d busy", c), busy, e_busy[c-1]);
      if (e_valid[c-1] != 0) chk($sformatf("4beat c%0d data", c), tx_data, e_data[c-1]);
      step();
    end
    exp_fc = 32'd1;
    chk("4beat done width", done, 0);
    chk("4beat frame_count", frame_count, exp_fc);
    chk("4beat dest", {tx_dest_ip, tx_dest_port}, {32'hC0A8_0001, 16'd5000});

    // Odd length: final low beat carries eof, addr peaks at 1
    run_frame(3, 32'h0DD0_0003, 0, 0, 0);

    // Back-pressure over a 64-beat frame
    run_frame(64, 32'hBAC0_0040, 1, 0, 0);

    // Start mid-frame with a different IP and length is ignored
    run_frame(20, 32'h5A5A_0014, 2, 0, 0);

    // Reset after beat 5 of 16
    run_frame(16, 32'h7E57_0010, 0, 0, 5);

    // Overflow in a frame: sticky afterwards
    run_frame(10, 32'h0F10_000A, 0, 6, 0);

    // Zero-length start: ignored, overflow flag kept
    start = 1'b1; num_words = '0; dest_ip = 32'h0101_0101; dest_port = 16'h0101;
    step();
    start = 1'b0;
    chk("zero-len busy", busy, 0);
    chk("zero-len ovf kept", overflow_err, 1);
    chk("zero-len en", bram_en_a, 0);
    step();
    chk("zero-len done", {done, busy}, 0);

    // Next accepted start clears overflow (checked at cycle 1 inside)
    run_frame(5, 32'h0C1E_0005, 0, 0, 0);

    // Largest length the 14-bit num_words field can express: 16383 beats,
    // all 8192 words fetched, eof on beat 16382
    run_frame(16383, 32'hFFFF_3FFF, 0, 0, 0);

    // Frame counter wrap
    force dut.frame_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    @(negedge clk);
    chk("fc preset", frame_count, 32'hFFFF_FFFF);
    exp_fc = 32'hFFFF_FFFF;
    run_frame(4, 32'hF0F0_0004, 0, 0, 0);
    chk("fc wrapped to zero", frame_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
